// File: rtl/stall_control_unit.sv
// Front-end stall controller for the 16-bit MIPS pipeline.
// Decodes halt/jump/load in decode and holds IF/ID for a configurable number of cycles.
module stall_control_unit #(
  parameter int unsigned     OP_W      = 6,
  parameter logic [OP_W-1:0] OP_HLT    = 6'b010001,
  parameter logic [OP_W-1:0] OP_LD     = 6'b010100,
  parameter logic [OP_W-1:0] OP_JMP    = 6'b011110,
  parameter int unsigned     LD_STALL  = 1,
  parameter int unsigned     JMP_STALL = 2,
  parameter int unsigned     CNT_W     = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op,
  input  logic             op_valid,
  input  logic             resume,
  output logic             stall,
  output logic             stall_pm,
  output logic             flush,
  output logic             halted,
  output logic [CNT_W-1:0] busy_cnt
);

  localparam logic [CNT_W-1:0] LD_CNT  = CNT_W'(LD_STALL);
  localparam logic [CNT_W-1:0] JMP_CNT = CNT_W'(JMP_STALL);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             is_hlt;
  logic             is_jmp;
  logic             is_ld;

  // Opcode decode; priority HLT > JMP > LD is applied in the FSM.
  always_comb begin
    is_hlt = op_valid && (op == OP_HLT);
    is_jmp = op_valid && (op == OP_JMP);
    is_ld  = op_valid && (op == OP_LD);
  end

  assign stall    = (state != RUN) || is_hlt || is_jmp || is_ld;
  assign halted   = (state == HALT);
  assign busy_cnt = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      cnt      <= '0;
      stall_pm <= 1'b0;
      flush    <= 1'b0;
    end else begin
      stall_pm <= stall;
      flush    <= 1'b0;
      case (state)
        RUN: begin
          if (is_hlt) begin
            state <= HALT;
          end else if (is_jmp) begin
            flush <= 1'b1;
            if (JMP_CNT != '0) begin
              state <= STALL;
              cnt   <= JMP_CNT;
            end
          end else if (is_ld) begin
            if (LD_CNT != '0) begin
              state <= STALL;
              cnt   <= LD_CNT;
            end
          end
        end
        STALL: begin
          // The cycle with cnt==1 is the last held cycle.
          if (cnt <= CNT_W'(1)) begin
            state <= RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HALT: begin
          if (resume) state <= RUN;
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
